// File: rtl/clock_div_pkg.sv
// rtl/clock_div_pkg.sv - shared types, constants and ratio normalization for the clock divider controller
package clock_div_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_GATE   = 2'd1,
      S_LOAD   = 2'd2,
      S_SETTLE = 2'd3
   } state_e;

   localparam int GATE_CYC = 2;

   // Ratio 1 would stall the divider, so it is redirected to bypass (0).
   function automatic int unsigned normalize(input int unsigned n);
      return (n == 32'd1) ? 32'd0 : n;
   endfunction

endpackage

// File: rtl/clock_div_ctrl_if.sv
// rtl/clock_div_ctrl_if.sv - ratio change request handshake between requester and divider controller
interface clock_div_ctrl_if #(
   parameter int SIZE = 3
);
   logic            req_valid;
   logic            req_ready;
   logic [SIZE-1:0] req_n;

   modport master (output req_valid, output req_n, input req_ready);
   modport slave  (input req_valid, input req_n, output req_ready);
endinterface

// File: rtl/clock_div_ctrl.sv
// rtl/clock_div_ctrl.sv - sequences divide-ratio changes as gate, load, settle, release
// Optional config lock is built with CLK_DIV_LOCK_EN; reset ratio comes from `CLK_DIV.
`ifndef CLK_DIV
`define CLK_DIV 2
`endif

module clock_div_ctrl
   import clock_div_pkg::*;
#(
   parameter int SIZE   = 3,
   parameter int SETTLE = 32
) (
   input  logic              clk,
   input  logic              resetb,
   clock_div_ctrl_if.slave   req,
   input  logic              lock,
   output logic [SIZE-1:0]   div_n,
   output logic              div_gate,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int CW = $clog2(SETTLE) + 1;

   state_e          r_state;
   logic [CW-1:0]   r_cnt;
   logic [SIZE-1:0] r_div_n;
   logic [SIZE-1:0] r_pend;
   logic            r_done;
   logic            r_err;

   logic            w_xfer;
   logic            w_locked;
   logic [SIZE-1:0] w_nreq;

   assign w_xfer = req.req_valid && (r_state == S_IDLE);
   assign w_nreq = SIZE'(normalize(32'(req.req_n)));

`ifdef CLK_DIV_LOCK_EN
   logic r_locked;

   // Lock only latches while idle so an in-flight change always completes.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         r_locked <= 1'b0;
      end else if (lock && (r_state == S_IDLE)) begin
         r_locked <= 1'b1;
      end
   end

   assign w_locked = r_locked;
`else
   logic w_unused_lock;

   assign w_unused_lock = lock;
   assign w_locked      = 1'b0;
`endif

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_div_n <= SIZE'(`CLK_DIV);
         r_pend  <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_xfer) begin
                  if (w_locked) begin
                     r_err <= 1'b1;
                  end else if (w_nreq == r_div_n) begin
                     r_done <= 1'b1;
                  end else begin
                     r_pend  <= w_nreq;
                     r_cnt   <= CW'(GATE_CYC - 1);
                     r_state <= S_GATE;
                  end
               end
            end
            S_GATE: begin
               if (r_cnt == '0) begin
                  r_state <= S_LOAD;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_LOAD: begin
               r_div_n <= r_pend;
               r_cnt   <= CW'(SETTLE - 1);
               r_state <= S_SETTLE;
            end
            S_SETTLE: begin
               // Holds the gate until the divider's synchronizer has seen the new ratio.
               if (r_cnt == '0) begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign req.req_ready = (r_state == S_IDLE);
   assign div_n         = r_div_n;
   assign div_gate      = (r_state != S_IDLE);
   assign busy          = (r_state != S_IDLE);
   assign done          = r_done;
   assign err           = r_err;

endmodule

// File: tb/tb_clock_div_ctrl.sv
// tb/tb_clock_div_ctrl.sv - directed self-checking bench for clock_div_ctrl (SIZE=3, SETTLE=32, reset ratio 2)
`ifndef CLK_DIV
`define CLK_DIV 2
`endif

module tb_clock_div_ctrl;

   logic       clk;
   logic       resetb;
   logic       lock;
   logic [2:0] div_n;
   logic       div_gate;
   logic       busy;
   logic       done;
   logic       err;

   int n_vec = 0;
   int n_err = 0;

   clock_div_ctrl_if #(.SIZE(3)) u_if ();

   clock_div_ctrl #(.SIZE(3), .SETTLE(32)) u_dut (
      .clk      (clk),
      .resetb   (resetb),
      .req      (u_if),
      .lock     (lock),
      .div_n    (div_n),
      .div_gate (div_gate),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic xfer(input logic [2:0] n);
      u_if.req_n     = n;
      u_if.req_valid = 1'b1;
      tick();
      u_if.req_valid = 1'b0;
   endtask

   task automatic wait_done(input int start, output int cyc);
      cyc = start;
      while (!done && cyc < 60) begin
         tick();
         cyc++;
      end
   endtask

   task automatic test_reset();
      resetb = 1'b0; lock = 1'b0; u_if.req_valid = 1'b0; u_if.req_n = 3'd0;
      repeat (3) tick();
      resetb = 1'b1;
      repeat (10) tick();
      n_vec++; if (div_n !== 3'd2) begin n_err++; $display("FAIL reset_div_n got=%0d exp=2", div_n); end
      n_vec++; if (div_gate !== 1'b0) begin n_err++; $display("FAIL reset_gate got=%b exp=0", div_gate); end
      n_vec++; if (u_if.req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", u_if.req_ready); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_vec++; if (done !== 1'b0 || err !== 1'b0) begin n_err++; $display("FAIL reset_done_err got=%b%b exp=00", done, err); end
   endtask

   task automatic test_change();
      int c;
      xfer(3'd5);
      n_vec++; if (div_gate !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL chg_gate_t1 got=%b%b exp=11", div_gate, busy); end
      n_vec++; if (u_if.req_ready !== 1'b0) begin n_err++; $display("FAIL chg_ready_t1 got=%b exp=0", u_if.req_ready); end
      tick(); tick();
      n_vec++; if (div_n !== 3'd2) begin n_err++; $display("FAIL chg_div_n_t2 got=%0d exp=2", div_n); end
      tick();
      n_vec++; if (div_n !== 3'd5) begin n_err++; $display("FAIL chg_div_n_t3 got=%0d exp=5", div_n); end
      wait_done(3, c);
      n_vec++; if (c !== 35) begin n_err++; $display("FAIL chg_done_cycle got=%0d exp=35", c); end
      n_vec++; if (div_gate !== 1'b0 || busy !== 1'b0 || u_if.req_ready !== 1'b1) begin n_err++; $display("FAIL chg_release got=%b%b%b exp=001", div_gate, busy, u_if.req_ready); end
      tick();
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL chg_done_width got=%b exp=0", done); end
      n_vec++; if (div_n !== 3'd5) begin n_err++; $display("FAIL chg_div_n_final got=%0d exp=5", div_n); end
   endtask

   task automatic test_bypass();
      int c;
      xfer(3'd1);
      wait_done(0, c);
      n_vec++; if (c !== 35) begin n_err++; $display("FAIL byp_done_cycle got=%0d exp=35", c); end
      n_vec++; if (div_n !== 3'd0) begin n_err++; $display("FAIL byp_div_n got=%0d exp=0", div_n); end
      tick();
      u_if.req_n = 3'd0; u_if.req_valid = 1'b1;
      tick();
      n_vec++; if (done !== 1'b1 || busy !== 1'b0 || u_if.req_ready !== 1'b1) begin n_err++; $display("FAIL noop1 got=%b%b%b exp=101", done, busy, u_if.req_ready); end
      tick();
      n_vec++; if (done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL noop2 got=%b%b exp=10", done, busy); end
      u_if.req_valid = 1'b0;
      tick();
      n_vec++; if (done !== 1'b0 || busy !== 1'b0 || div_n !== 3'd0) begin n_err++; $display("FAIL noop_end got=%b%b/%0d exp=00/0", done, busy, div_n); end
   endtask

   task automatic test_reset_mid();
      int c;
      xfer(3'd2);
      wait_done(0, c);
      n_vec++; if (div_n !== 3'd2) begin n_err++; $display("FAIL rm_pre_div_n got=%0d exp=2", div_n); end
      tick();
      xfer(3'd7);
      repeat (9) tick();
      n_vec++; if (div_n !== 3'd7 || div_gate !== 1'b1) begin n_err++; $display("FAIL rm_settle got=%0d/%b exp=7/1", div_n, div_gate); end
      #2 resetb = 1'b0;
      #1;
      n_vec++; if (div_n !== 3'd2 || div_gate !== 1'b0) begin n_err++; $display("FAIL rm_async got=%0d/%b exp=2/0", div_n, div_gate); end
      n_vec++; if (busy !== 1'b0 || u_if.req_ready !== 1'b1) begin n_err++; $display("FAIL rm_async_hs got=%b%b exp=01", busy, u_if.req_ready); end
      tick();
      resetb = 1'b1;
      tick();
      xfer(3'd4);
      n_vec++; if (div_gate !== 1'b1) begin n_err++; $display("FAIL rm_after_gate got=%b exp=1", div_gate); end
      wait_done(0, c);
      n_vec++; if (c !== 35 || div_n !== 3'd4) begin n_err++; $display("FAIL rm_after_seq got=%0d/%0d exp=35/4", c, div_n); end
      tick();
   endtask

   task automatic test_back_to_back();
      int c;
      u_if.req_n = 3'd3; u_if.req_valid = 1'b1;
      tick();
      c = 0;
      while (!done && c < 60) begin
         u_if.req_n = 3'(c + 1);
         tick();
         c++;
         if (c == 3) begin
            n_vec++; if (div_n !== 3'd3) begin n_err++; $display("FAIL b2b_loaded got=%0d exp=3", div_n); end
         end
      end
      n_vec++; if (c !== 35) begin n_err++; $display("FAIL b2b_done_cycle got=%0d exp=35", c); end
      u_if.req_n = 3'd6;
      tick();
      n_vec++; if (busy !== 1'b1 || u_if.req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_next_xfer got=%b%b exp=10", busy, u_if.req_ready); end
      u_if.req_valid = 1'b0;
      wait_done(0, c);
      n_vec++; if (c !== 35 || div_n !== 3'd6) begin n_err++; $display("FAIL b2b_second got=%0d/%0d exp=35/6", c, div_n); end
      tick();
   endtask

   task automatic test_lock();
      int c;
      lock = 1'b1;
      tick();
      lock = 1'b0;
      tick();
      xfer(3'd5);
`ifdef CLK_DIV_LOCK_EN
      n_vec++; if (err !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL lock_err got=%b%b exp=10", err, done); end
      n_vec++; if (div_gate !== 1'b0 || div_n !== 3'd6) begin n_err++; $display("FAIL lock_hold got=%b/%0d exp=0/6", div_gate, div_n); end
      tick();
      n_vec++; if (err !== 1'b0 || div_gate !== 1'b0) begin n_err++; $display("FAIL lock_after got=%b%b exp=00", err, div_gate); end
`else
      n_vec++; if (div_gate !== 1'b1 || err !== 1'b0) begin n_err++; $display("FAIL nolock_start got=%b%b exp=10", div_gate, err); end
      wait_done(0, c);
      n_vec++; if (c !== 35 || div_n !== 3'd5) begin n_err++; $display("FAIL nolock_seq got=%0d/%0d exp=35/5", c, div_n); end
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_change();
      test_bypass();
      test_reset_mid();
      test_back_to_back();
      test_lock();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
